// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - two-source writeback request bundle (ALU port 0, load port 1)
interface regfile_write_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  Valid0;
  logic                  Valid1;
  logic                  Ready0;
  logic                  Ready1;
  logic [ADDR_WIDTH-1:0] Target0;
  logic [ADDR_WIDTH-1:0] Target1;
  logic [DATA_WIDTH-1:0] Data0;
  logic [DATA_WIDTH-1:0] Data1;

  modport slave (
    input  Valid0, Valid1, Target0, Target1, Data0, Data1,
    output Ready0, Ready1
  );

  modport master (
    output Valid0, Valid1, Target0, Target1, Data0, Data1,
    input  Ready0, Ready1
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter for the register file's single write port
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  regfile_write_arbiter_if.slave req,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic [ADDR_WIDTH-1:0] WriteTarget,
  output logic                  WriteEnable,
  output logic [CNT_WIDTH-1:0]  ConflictCount
);

  logic                  last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
  logic [ADDR_WIDTH-1:0] write_target_q, write_target_d;
  logic                  write_enable_q, write_enable_d;
  logic [CNT_WIDTH-1:0]  conflict_count_q, conflict_count_d;

  logic ready0, ready1;
  logic grant0, grant1;
  logic conflict;

  // Ready depends only on the other port's Valid and the round-robin pointer.
  always_comb begin
    ready0   = !(req.Valid1 && !last_grant_q);
    ready1   = !(req.Valid0 && last_grant_q);
    grant0   = req.Valid0 && ready0;
    grant1   = req.Valid1 && ready1;
    conflict = req.Valid0 && req.Valid1;
  end

  assign req.Ready0 = ready0;
  assign req.Ready1 = ready1;

  always_comb begin
    write_data_d     = write_data_q;
    write_target_d   = write_target_q;
    write_enable_d   = 1'b0;
    last_grant_d     = last_grant_q;
    conflict_count_d = conflict_count_q;

    if (grant0) begin
      write_data_d   = req.Data0;
      write_target_d = req.Target0;
      write_enable_d = |req.Target0;
    end else if (grant1) begin
      write_data_d   = req.Data1;
      write_target_d = req.Target1;
      write_enable_d = |req.Target1;
    end

    // The pointer moves only when both ports compete; uncontested grants leave it alone.
    if (conflict) begin
      last_grant_d = !last_grant_q;
      if (conflict_count_q != {CNT_WIDTH{1'b1}}) begin
        conflict_count_d = conflict_count_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      last_grant_q     <= 1'b1;
      write_data_q     <= '0;
      write_target_q   <= '0;
      write_enable_q   <= 1'b0;
      conflict_count_q <= '0;
    end else begin
      last_grant_q     <= last_grant_d;
      write_data_q     <= write_data_d;
      write_target_q   <= write_target_d;
      write_enable_q   <= write_enable_d;
      conflict_count_q <= conflict_count_d;
    end
  end

  assign WriteData     = write_data_q;
  assign WriteTarget   = write_target_q;
  assign WriteEnable   = write_enable_q;
  assign ConflictCount = conflict_count_q;

endmodule
